// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint controller driving the core run enable.
// Define RUN_CTRL_CNT_EN to build the retired-instruction counter.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_BP = 2,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_sw,
  input  logic                  step_btn,
  input  logic [1:0]            mode,
  input  logic [31:0]           pc,
  input  logic [32*NUM_BP-1:0]  bp_addr,
  input  logic [NUM_BP-1:0]     bp_en,
  output logic                  run,
  output logic                  halted,
  output logic                  bp_hit,
  output logic [2:0]            bp_idx,
  output logic [CNT_W-1:0]      instr_cnt,
  output logic [31:0]           disp_data
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0] M_FREE  = 2'b00;
  localparam logic [1:0] M_STEP  = 2'b01;
  localparam logic [1:0] M_BREAK = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    S_HALT,
    S_RUN,
    S_STEP
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      run_sync, step_sync;
  logic [1:0]      mode_s1, mode_s2;
  logic [DW-1:0]   run_db, step_db;
  logic            run_acc, step_acc, step_prev;
  logic            step_pulse, hold, leave;
  logic            match, hit_now, skip;
  logic [2:0]      match_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_sync  <= '0;
      step_sync <= '0;
      mode_s1   <= '0;
      mode_s2   <= '0;
    end else begin
      run_sync  <= {run_sync[0], run_sw};
      step_sync <= {step_sync[0], step_btn};
      mode_s1   <= mode;
      mode_s2   <= mode_s1;
    end
  end

  // Accepted level flips only after DEBOUNCE_CYCLES consecutive disagreements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_db    <= '0;
      step_db   <= '0;
      run_acc   <= 1'b0;
      step_acc  <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_prev <= step_acc;
      if (run_sync[1] == run_acc) begin
        run_db <= '0;
      end else if (run_db == DW'(DEBOUNCE_CYCLES - 1)) begin
        run_acc <= run_sync[1];
        run_db  <= '0;
      end else begin
        run_db <= run_db + DW'(1);
      end
      if (step_sync[1] == step_acc) begin
        step_db <= '0;
      end else if (step_db == DW'(DEBOUNCE_CYCLES - 1)) begin
        step_acc <= step_sync[1];
        step_db  <= '0;
      end else begin
        step_db <= step_db + DW'(1);
      end
    end
  end

  assign step_pulse = step_acc & ~step_prev;
  assign hold       = (mode_s2 == M_HOLD);

  // Descending scan so the lowest matching index wins.
  always_comb begin
    match     = 1'b0;
    match_idx = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_addr[32*i +: 32])) begin
        match     = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  assign hit_now = (mode_s2 == M_BREAK) && !skip && match;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_HALT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_HALT: begin
        if (!hold) begin
          if (run_acc && (mode_s2 == M_FREE || mode_s2 == M_BREAK))
            state_nx = S_RUN;
          else if (step_pulse && (mode_s2 == M_STEP || mode_s2 == M_BREAK))
            state_nx = S_STEP;
        end
      end
      S_RUN: begin
        if (hold || !run_acc || mode_s2 == M_STEP || hit_now)
          state_nx = S_HALT;
      end
      S_STEP:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

  always_comb begin
    run    = ((state == S_RUN) && !hit_now) || (state == S_STEP);
    halted = (state == S_HALT);
    leave  = (state == S_HALT) && (state_nx != S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_hit <= 1'b0;
      bp_idx <= 3'd0;
      skip   <= 1'b0;
    end else begin
      if ((state == S_RUN) && hit_now) begin
        bp_hit <= 1'b1;
        bp_idx <= match_idx;
      end else if (leave) begin
        bp_hit <= 1'b0;
      end
      if (leave)    skip <= 1'b1;
      else if (run) skip <= 1'b0;
    end
  end

`ifdef RUN_CTRL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)   instr_cnt <= '0;
    else if (run) instr_cnt <= instr_cnt + CNT_W'(1);
  end
`else
  assign instr_cnt = '0;
`endif

  assign disp_data = halted ? pc : 32'(instr_cnt);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized scenarios against a behavioural model.
// Counter expectations follow RUN_CTRL_CNT_EN.
module tb_cpu_run_ctrl;

  localparam int D  = 4;
  localparam int NB = 2;
  localparam int CW = 16;
`ifdef RUN_CTRL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, run_sw, step_btn;
  logic [1:0]    mode;
  logic [31:0]   pc;
  logic [63:0]   bp_addr;
  logic [1:0]    bp_en;
  logic          run, halted, bp_hit;
  logic [2:0]    bp_idx;
  logic [CW-1:0] instr_cnt;
  logic [31:0]   disp_data;
  logic          pc_load;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(D), .NUM_BP(NB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn),
    .mode(mode), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .run(run), .halted(halted), .bp_hit(bp_hit), .bp_idx(bp_idx),
    .instr_cnt(instr_cnt), .disp_data(disp_data)
  );

  // Core stand-in: PC advances by one instruction per enabled cycle.
  always @(posedge clk) begin
    if (pc_load)  pc <= 32'h0;
    else if (run) pc <= pc + 32'd4;
  end

  // Reference model: raw -> 2-cycle delay -> D-stable acceptance -> modes.
  bit          m_r1, m_r2, m_s1, m_s2, m_ar, m_as, m_asp;
  bit [1:0]    m_md1, m_md2;
  int          m_dr, m_ds;
  bit          m_halt, m_going, m_stepping;
  bit          m_skip, m_bph;
  bit [2:0]    m_bpi;
  int unsigned m_icnt;
  bit          r_now, h_now, p_now, leaving, go_run, go_step, stop;
  int          idx_now;

  function automatic int m_match();
    for (int i = 0; i < NB; i++)
      if (bp_en[i] && pc == bp_addr[32*i +: 32]) return i;
    return -1;
  endfunction

  function automatic bit m_hit();
    return m_md2 == 2'b10 && !m_skip && m_match() >= 0;
  endfunction

  function automatic bit m_run();
    return (m_going && !m_hit()) || m_stepping;
  endfunction

  function automatic logic [CW-1:0] exp_cnt(int unsigned v);
    return CNT_ON ? CW'(v % 65536) : '0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      {m_r1, m_r2, m_s1, m_s2, m_ar, m_as, m_asp} = '0;
      m_md1 = 0; m_md2 = 0; m_dr = 0; m_ds = 0;
      m_halt = 1; m_going = 0; m_stepping = 0;
      m_skip = 0; m_bph = 0; m_bpi = 0; m_icnt = 0;
    end else begin
      r_now   = m_run();
      h_now   = m_hit();
      idx_now = m_match();
      p_now   = m_as && !m_asp;
      go_run  = m_ar && (m_md2 == 2'b00 || m_md2 == 2'b10);
      go_step = p_now && (m_md2 == 2'b01 || m_md2 == 2'b10);
      stop    = h_now || !m_ar || m_md2 == 2'b01;
      leaving = m_halt && m_md2 != 2'b11 && (go_run || go_step);
      if (m_going && h_now) begin
        m_bph = 1;
        m_bpi = 3'(idx_now);
      end else if (leaving) begin
        m_bph = 0;
      end
      if (leaving)    m_skip = 1;
      else if (r_now) m_skip = 0;
      if (r_now) m_icnt = m_icnt + 1;
      if (m_md2 == 2'b11 || m_stepping || (m_going && stop)) begin
        m_halt = 1; m_going = 0; m_stepping = 0;
      end else if (leaving) begin
        m_halt = 0; m_going = go_run; m_stepping = !go_run;
      end
      m_asp = m_as;
      if (m_r2 != m_ar) m_dr++; else m_dr = 0;
      if (m_dr == D) begin m_ar = m_r2; m_dr = 0; end
      if (m_s2 != m_as) m_ds++; else m_ds = 0;
      if (m_ds == D) begin m_as = m_s2; m_ds = 0; end
      m_r2 = m_r1; m_r1 = run_sw;
      m_s2 = m_s1; m_s1 = step_btn;
      m_md2 = m_md1; m_md1 = mode;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pc_load = 1'b1;
    tick(2);
    rst_n = 1'b1; pc_load = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 0; run_sw = 1; step_btn = 0; mode = 0;
    bp_en = 0; bp_addr = 0; pc_load = 1;
    tick(3);
    n_chk++; if (run !== 1'b0) begin n_err++; $display("FAIL reset_run got %b want 0", run); end
    n_chk++; if (halted !== 1'b1) begin n_err++; $display("FAIL reset_halted got %b want 1", halted); end
    n_chk++; if (instr_cnt !== '0) begin n_err++; $display("FAIL reset_cnt got %h want 0", instr_cnt); end
    n_chk++; if (bp_hit !== 1'b0 || bp_idx !== 3'd0) begin n_err++; $display("FAIL reset_bp got %b/%0d want 0/0", bp_hit, bp_idx); end
    n_chk++; if (disp_data !== 32'h0) begin n_err++; $display("FAIL reset_disp got %h want 0", disp_data); end
    rst_n = 1; pc_load = 0;
    lat = 0;
    while (run !== 1'b1 && lat < 20) begin
      tick(); lat++;
      n_chk++; if (run !== m_run()) begin n_err++; $display("FAIL reset_model_run got %b want %b", run, m_run()); end
    end
    n_chk++; if (lat != 7) begin n_err++; $display("FAIL reset_latency got %0d want 7", lat); end
  endtask

  task automatic test_reset_mid();
    tick(3);
    n_chk++; if (run !== 1'b1) begin n_err++; $display("FAIL mid_running got %b want 1", run); end
    rst_n = 0;
    tick();
    n_chk++; if (run !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL mid_reset got run=%b halted=%b want 0/1", run, halted); end
    n_chk++; if (instr_cnt !== '0) begin n_err++; $display("FAIL mid_cnt got %h want 0", instr_cnt); end
  endtask

  task automatic test_bounce();
    int lat;
    int ph;
    run_sw = 0; mode = 0;
    do_reset();
    tick(8);
    ph = $urandom_range(0, 2);
    for (int i = 0; i < 30; i++) begin
      run_sw = (((i + ph) / 3) % 2 == 0);
      tick();
      n_chk++; if (run !== 1'b0) begin n_err++; $display("FAIL bounce_run cyc %0d got %b want 0", i, run); end
    end
    run_sw = 0;
    tick(8);
    run_sw = 1;
    lat = 0;
    while (run !== 1'b1 && lat < 20) begin
      tick(); lat++;
      n_chk++; if (run !== m_run()) begin n_err++; $display("FAIL bounce_model_run got %b want %b", run, m_run()); end
    end
    n_chk++; if (lat != 7) begin n_err++; $display("FAIL bounce_latency got %0d want 7", lat); end
  endtask

  task automatic test_step();
    int nrun;
    int hold_len;
    run_sw = 0; mode = 2'b01;
    do_reset();
    tick(6);
    nrun = 0;
    hold_len = 20 + $urandom_range(0, 10);
    step_btn = 1;
    for (int i = 0; i < hold_len + 12; i++) begin
      if (i == hold_len) step_btn = 0;
      tick();
      if (run === 1'b1) nrun++;
      n_chk++; if (run !== m_run()) begin n_err++; $display("FAIL step_model_run cyc %0d got %b want %b", i, run, m_run()); end
    end
    n_chk++; if (nrun != 1) begin n_err++; $display("FAIL step_count got %0d want 1", nrun); end
    n_chk++; if (pc !== 32'h4) begin n_err++; $display("FAIL step_pc got %h want 4", pc); end
    n_chk++; if (instr_cnt !== exp_cnt(1)) begin n_err++; $display("FAIL step_cnt got %h want %h", instr_cnt, exp_cnt(1)); end
  endtask

  task automatic test_breakpoint();
    int guard;
    run_sw = 0; mode = 2'b10;
    bp_addr = {32'h10, 32'h8}; bp_en = 2'b10;
    do_reset();
    tick(6);
    run_sw = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (run !== m_run()) begin n_err++; $display("FAIL bp_model_run got %b want %b", run, m_run()); end
    end
    run_sw = 0;
    guard = 0;
    while (bp_hit !== 1'b1 && guard < 30) begin
      tick(); guard++;
      n_chk++; if (run !== m_run() || halted !== m_halt) begin n_err++; $display("FAIL bp_model got run=%b halted=%b want %b/%b", run, halted, m_run(), m_halt); end
    end
    n_chk++; if (halted !== 1'b1 || pc !== 32'h10) begin n_err++; $display("FAIL bp_halt got halted=%b pc=%h want 1/00000010", halted, pc); end
    n_chk++; if (bp_hit !== 1'b1 || bp_idx !== 3'd1) begin n_err++; $display("FAIL bp_flag got %b/%0d want 1/1", bp_hit, bp_idx); end
    n_chk++; if (instr_cnt !== exp_cnt(4)) begin n_err++; $display("FAIL bp_cnt got %h want %h", instr_cnt, exp_cnt(4)); end
    n_chk++; if (disp_data !== 32'h10) begin n_err++; $display("FAIL bp_disp got %h want 10", disp_data); end
    tick(8);
    n_chk++; if (halted !== 1'b1 || pc !== 32'h10) begin n_err++; $display("FAIL bp_stay got halted=%b pc=%h want 1/10", halted, pc); end
    step_btn = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) step_btn = 0;
      tick();
      n_chk++; if (run !== m_run() || bp_hit !== m_bph) begin n_err++; $display("FAIL bp_step_model got run=%b hit=%b want %b/%b", run, bp_hit, m_run(), m_bph); end
    end
    n_chk++; if (pc !== 32'h14 || bp_hit !== 1'b0) begin n_err++; $display("FAIL bp_resume got pc=%h hit=%b want 14/0", pc, bp_hit); end
    n_chk++; if (instr_cnt !== exp_cnt(5)) begin n_err++; $display("FAIL bp_resume_cnt got %h want %h", instr_cnt, exp_cnt(5)); end
  endtask

  task automatic test_hold();
    int guard;
    run_sw = 1; mode = 0; bp_en = 0;
    do_reset();
    guard = 0;
    while (run !== 1'b1 && guard < 20) begin tick(); guard++; end
    n_chk++; if (run !== 1'b1) begin n_err++; $display("FAIL hold_start got %b want 1", run); end
    tick($urandom_range(1, 5));
    mode = 2'b11;
    tick();
    n_chk++; if (run !== 1'b1) begin n_err++; $display("FAIL hold_edge1 got %b want 1", run); end
    tick();
    n_chk++; if (run !== 1'b1) begin n_err++; $display("FAIL hold_edge2 got %b want 1", run); end
    tick();
    n_chk++; if (run !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL hold_edge3 got run=%b halted=%b want 0/1", run, halted); end
    step_btn = 1;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) step_btn = 0;
      tick();
      n_chk++; if (run !== 1'b0 || run !== m_run()) begin n_err++; $display("FAIL hold_ignore cyc %0d got %b want 0", i, run); end
    end
  endtask

  task automatic test_wrap();
    int guard;
    run_sw = 1; mode = 0; bp_en = 0;
    do_reset();
    guard = 0;
    while (m_icnt != 32'hFFFE && guard < 70000) begin tick(); guard++; end
    n_chk++; if (guard >= 70000) begin n_err++; $display("FAIL wrap_timeout got %0d cycles want <70000", guard); end
    n_chk++; if (instr_cnt !== exp_cnt(32'hFFFE)) begin n_err++; $display("FAIL wrap_fffe got %h want %h", instr_cnt, exp_cnt(32'hFFFE)); end
    tick();
    n_chk++; if (instr_cnt !== exp_cnt(32'hFFFF)) begin n_err++; $display("FAIL wrap_ffff got %h want %h", instr_cnt, exp_cnt(32'hFFFF)); end
    tick();
    n_chk++; if (instr_cnt !== exp_cnt(0)) begin n_err++; $display("FAIL wrap_0000 got %h want %h", instr_cnt, exp_cnt(0)); end
    tick();
    n_chk++; if (instr_cnt !== exp_cnt(1)) begin n_err++; $display("FAIL wrap_0001 got %h want %h", instr_cnt, exp_cnt(1)); end
    n_chk++; if (disp_data !== 32'(exp_cnt(1))) begin n_err++; $display("FAIL wrap_disp got %h want %h", disp_data, 32'(exp_cnt(1))); end
  endtask

  initial begin
    rst_n = 0; run_sw = 0; step_btn = 0; mode = 0;
    bp_addr = 0; bp_en = 0; pc_load = 1;
    test_reset();
    test_reset_mid();
    test_bounce();
    test_step();
    test_breakpoint();
    test_hold();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
